console_uart_tx: RTL



---
 rtl/console_pkg.sv | 15 +
 rtl/console_fifo.sv | 54 +++++
 rtl/console_uart_tx.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/console_pkg.sv
// Shared constants and types for the console UART sink on the CPU data bus.
package console_pkg;

    localparam logic [31:0] FINI_CODE_DEFAULT = 32'h0002_0000;
    localparam int          SEL_BIT           = 31;
    localparam int          FRAME_BITS        = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/console_fifo.sv
// Synchronous character FIFO; an extra pointer bit separates full from empty.
module console_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign count     = wr_ptr_r - rd_ptr_r;
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign rdata     = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; a push at full is refused even when a pop happens alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array, written only on accepted pushes.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/console_uart_tx.sv
// Console sink: decodes MMIO stores, queues characters and serializes them 8N1,
// then reports the finish request once everything queued has left the pin.
module console_uart_tx
    import console_pkg::*;
#(
    parameter int          BAUD_DIV   = 868,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] FINI_CODE  = FINI_CODE_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] dbus_addr_i,
    input  logic        dbus_wvalid_i,
    input  logic [31:0] dbus_wdata_i,
    output logic        dbus_wready_o,
    output logic        txd_o,
    output logic        busy_o,
    output logic        fini_o,
    output logic        drop_o
);

    localparam int CW = $clog2(FIFO_DEPTH);

    uart_state_t state_r;
    logic [15:0] baud_cnt_r;
    logic [2:0]  bit_idx_r;
    logic [7:0]  shift_r;
    logic        txd_r;
    logic        drop_r;
    logic        fini_pending_r;

    logic        sel_s;
    logic        wready_s;
    logic        accept_s;
    logic        is_fini_s;
    logic        push_s;
    logic        pop_s;
    logic        last_s;
    logic        fifo_full_s;
    logic        fifo_empty_s;
    logic [7:0]  fifo_rdata_s;
    logic [CW:0] fifo_count_s;
    logic [30:0] unused_addr_s;

    assign unused_addr_s = dbus_addr_i[30:0];

    // wready depends on registered state only, so the core sees no comb loop.
    assign sel_s     = dbus_wvalid_i & dbus_addr_i[SEL_BIT];
    assign wready_s  = ~fifo_full_s & ~fini_pending_r;
    assign accept_s  = sel_s & wready_s;
    assign is_fini_s = (dbus_wdata_i == FINI_CODE);
    assign push_s    = accept_s & ~is_fini_s;
    assign last_s    = (baud_cnt_r == 16'(BAUD_DIV - 1));
    assign pop_s     = ~fifo_empty_s & ((state_r == IDLE) | ((state_r == STOP) & last_s));

    assign dbus_wready_o = wready_s;
    assign txd_o         = txd_r;
    assign drop_o        = drop_r;
    assign busy_o        = (fifo_count_s != '0) | (state_r != IDLE);
    // Once pending with nothing queued and the FSM idle, no push can reopen the pipe: sticky.
    assign fini_o        = fini_pending_r & fifo_empty_s & (state_r == IDLE);

    console_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (push_s),
        .wdata (dbus_wdata_i[7:0]),
        .pop   (pop_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Serializer FSM with dbus bookkeeping; txd is driven from a flop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r        <= IDLE;
            baud_cnt_r     <= 16'd0;
            bit_idx_r      <= 3'd0;
            shift_r        <= 8'd0;
            txd_r          <= 1'b1;
            drop_r         <= 1'b0;
            fini_pending_r <= 1'b0;
        end else begin
            drop_r <= sel_s & ~wready_s;
            if (accept_s && is_fini_s) begin
                fini_pending_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    baud_cnt_r <= 16'd0;
                    bit_idx_r  <= 3'd0;
                    if (pop_s) begin
                        shift_r <= fifo_rdata_s;
                        txd_r   <= 1'b0;
                        state_r <= START;
                    end else begin
                        txd_r   <= 1'b1;
                    end
                end
                START: begin
                    if (last_s) begin
                        baud_cnt_r <= 16'd0;
                        txd_r      <= shift_r[0];
                        state_r    <= DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end
                DATA: begin
                    if (last_s) begin
                        baud_cnt_r <= 16'd0;
                        if (bit_idx_r == 3'(FRAME_BITS - 3)) begin
                            txd_r   <= 1'b1;
                            state_r <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            shift_r   <= {1'b0, shift_r[7:1]};
                            txd_r     <= shift_r[1];
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end
                STOP: begin
                    if (last_s) begin
                        baud_cnt_r <= 16'd0;
                        bit_idx_r  <= 3'd0;
                        // Chain straight into the next frame when more characters wait.
                        if (pop_s) begin
                            shift_r <= fifo_rdata_s;
                            txd_r   <= 1'b0;
                            state_r <= START;
                        end else begin
                            txd_r   <= 1'b1;
                            state_r <= IDLE;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end
                default: begin
                    baud_cnt_r <= 16'd0;
                    txd_r      <= 1'b1;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule
